// File: rtl/render_scheduler_if.sv
// Triangle source and rasterizer handshake bundle for render_scheduler.
// Signal directions are named from the scheduler's point of view.
interface render_scheduler_if #(
    parameter int unsigned DATAWIDTH  = 12,
    parameter int unsigned COLORWIDTH = 4
);
    localparam int unsigned VW = 3 * DATAWIDTH;

    logic                  i_tri_valid;
    logic                  o_tri_ready;
    logic [VW-1:0]         i_tri_v0;
    logic [VW-1:0]         i_tri_v1;
    logic [VW-1:0]         i_tri_v2;
    logic [COLORWIDTH-1:0] i_tri_color;
    logic                  i_tri_last;

    logic                  i_rast_ready;
    logic [VW-1:0]         o_rast_v0;
    logic [VW-1:0]         o_rast_v1;
    logic [VW-1:0]         o_rast_v2;
    logic                  o_rast_dv;
    logic                  o_rast_last;
    logic [COLORWIDTH-1:0] o_color;
    logic                  i_rast_finished;

    modport master (
        input  i_tri_valid, i_tri_v0, i_tri_v1, i_tri_v2, i_tri_color, i_tri_last,
        output o_tri_ready,
        input  i_rast_ready, i_rast_finished,
        output o_rast_v0, o_rast_v1, o_rast_v2, o_rast_dv, o_rast_last, o_color
    );

    modport slave (
        output i_tri_valid, i_tri_v0, i_tri_v1, i_tri_v2, i_tri_color, i_tri_last,
        input  o_tri_ready,
        output i_rast_ready, i_rast_finished,
        input  o_rast_v0, o_rast_v1, o_rast_v2, o_rast_dv, o_rast_last, o_color
    );
endinterface

// File: rtl/render_scheduler.sv
// Frame controller: queues triangles, clears the framebuffer on frame start, then
// issues queued triangles to the rasterizer one at a time until the last one finishes.
module render_scheduler #(
    parameter int unsigned DATAWIDTH  = 12,
    parameter int unsigned COLORWIDTH = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_frame_start,
    output logic        o_clear,
    input  logic        i_display_ready,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic        o_missed_frame,
    output logic [15:0] o_tri_count,
    render_scheduler_if.master sched_if
);
    localparam int unsigned VW = 3 * DATAWIDTH;
    localparam int unsigned EW = 3 * VW + COLORWIDTH + 1;
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StWaitClear,
        StFeed,
        StWaitRast,
        StDone
    } state_t;

    state_t r_state, w_state_d;

    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_full, w_empty, w_push, w_issue;
    logic [EW-1:0] w_head;

    logic                  r_guard_done;
    logic                  r_gap;
    logic [VW-1:0]         r_rast_v0, r_rast_v1, r_rast_v2;
    logic                  r_rast_dv, r_rast_last;
    logic [COLORWIDTH-1:0] r_color;
    logic [15:0]           r_tri_count;
    logic                  r_missed;

    assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = sched_if.i_tri_valid && !w_full;
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {sched_if.i_tri_last, sched_if.i_tri_color,
                                sched_if.i_tri_v2, sched_if.i_tri_v1, sched_if.i_tri_v0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= AW'(r_wr_ptr + 1'b1);
            end
            if (w_issue) begin
                r_rd_ptr <= AW'(r_rd_ptr + 1'b1);
            end
            if (w_push && !w_issue) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_issue) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_issue   = 1'b0;
        unique case (r_state)
            StIdle:      if (i_frame_start) w_state_d = StClear;
            StClear:     w_state_d = StWaitClear;
            // The display's ready lags o_clear by a cycle, so its first sample is stale.
            StWaitClear: if (r_guard_done && i_display_ready) w_state_d = StFeed;
            StFeed: begin
                if (!w_empty && sched_if.i_rast_ready && !r_gap) begin
                    w_issue = 1'b1;
                    if (w_head[EW-1]) w_state_d = StWaitRast;
                end
            end
            StWaitRast:  if (sched_if.i_rast_finished) w_state_d = StDone;
            StDone:      w_state_d = StIdle;
            default:     w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_guard_done <= 1'b0;
            r_gap        <= 1'b0;
            r_rast_v0    <= '0;
            r_rast_v1    <= '0;
            r_rast_v2    <= '0;
            r_rast_dv    <= 1'b0;
            r_rast_last  <= 1'b0;
            r_color      <= '0;
            r_tri_count  <= '0;
            r_missed     <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_guard_done <= (r_state == StWaitClear);
            // Rasterizer ready is stale for one cycle after each strobe.
            r_gap        <= w_issue;
            r_rast_dv    <= w_issue;
            if (w_issue) begin
                r_rast_v0   <= w_head[VW-1:0];
                r_rast_v1   <= w_head[2*VW-1:VW];
                r_rast_v2   <= w_head[3*VW-1:2*VW];
                r_color     <= w_head[3*VW+COLORWIDTH-1:3*VW];
                r_rast_last <= w_head[EW-1];
                if (r_tri_count != 16'hFFFF) r_tri_count <= r_tri_count + 16'd1;
            end else if (r_state == StDone) begin
                r_tri_count <= '0;
            end
            if (i_frame_start && (r_state != StIdle)) r_missed <= 1'b1;
        end
    end

    assign o_clear        = (r_state == StClear);
    assign o_frame_done   = (r_state == StDone);
    assign o_busy         = (r_state != StIdle);
    assign o_missed_frame = r_missed;
    assign o_tri_count    = r_tri_count;

    assign sched_if.o_tri_ready = !w_full;
    assign sched_if.o_rast_v0   = r_rast_v0;
    assign sched_if.o_rast_v1   = r_rast_v1;
    assign sched_if.o_rast_v2   = r_rast_v2;
    assign sched_if.o_rast_dv   = r_rast_dv;
    assign sched_if.o_rast_last = r_rast_last;
    assign sched_if.o_color     = r_color;
endmodule

// File: tb/tb_render_scheduler.sv
// Directed bench for render_scheduler: frame flow, FIFO full, colour hold,
// display stall, missed frame and mid-frame reset.
module tb_render_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        clear;
    logic        display_ready = 1'b0;
    logic        busy;
    logic        frame_done;
    logic        missed;
    logic [15:0] tri_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    render_scheduler_if #(.DATAWIDTH(12), .COLORWIDTH(4)) u_if ();

    render_scheduler #(.DATAWIDTH(12), .COLORWIDTH(4), .FIFO_DEPTH(4)) u_dut (
        .clk             (clk),
        .rst             (rst),
        .i_frame_start   (frame_start),
        .o_clear         (clear),
        .i_display_ready (display_ready),
        .o_busy          (busy),
        .o_frame_done    (frame_done),
        .o_missed_frame  (missed),
        .o_tri_count     (tri_count),
        .sched_if        (u_if)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] vtx(input int k);
        logic [11:0] x;
        x = 12'(k * 3);
        return {12'(k * 3 + 2), 12'(k * 3 + 1), x};
    endfunction

    task automatic push_tri(input int k, input logic last);
        u_if.i_tri_valid = 1'b1;
        u_if.i_tri_v0    = vtx(k);
        u_if.i_tri_v1    = vtx(k + 50);
        u_if.i_tri_v2    = vtx(k + 100);
        u_if.i_tri_color = 4'(k);
        u_if.i_tri_last  = last;
        tick();
        u_if.i_tri_valid = 1'b0;
    endtask

    // Returns with the current cycle holding o_rast_dv, or seen=0 after max cycles.
    task automatic wait_dv(input int max, output int when, output bit seen);
        seen = 1'b0;
        when = cyc;
        for (int n = 0; n < max && !seen; n++) begin
            if (u_if.o_rast_dv) seen = 1'b1;
            else tick();
        end
        when = cyc;
    endtask

    task automatic finish_frame(input string tag);
        u_if.i_rast_finished = 1'b1;
        tick();
        u_if.i_rast_finished = 1'b0;
        chk({tag, "_done_pulse"}, 64'(frame_done), 64'd1);
        tick();
        chk({tag, "_done_low"}, 64'(frame_done), 64'd0);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int          t, prev, rcyc;
        bit          seen;
        logic [3:0]  held;
        logic [3:0]  cols [3];

        u_if.i_tri_valid     = 1'b0;
        u_if.i_tri_v0        = '0;
        u_if.i_tri_v1        = '0;
        u_if.i_tri_v2        = '0;
        u_if.i_tri_color     = '0;
        u_if.i_tri_last      = 1'b0;
        u_if.i_rast_ready    = 1'b0;
        u_if.i_rast_finished = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_tri_ready", 64'(u_if.o_tri_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_clear", 64'(clear), 64'd0);
        chk("rst_dv", 64'(u_if.o_rast_dv), 64'd0);
        chk("rst_color", 64'(u_if.o_color), 64'd0);
        chk("rst_v0", 64'(u_if.o_rast_v0), 64'd0);
        chk("rst_count", 64'(tri_count), 64'd0);
        chk("rst_missed", 64'(missed), 64'd0);
        rst = 1'b0;
        tick();

        // Basic frame: three triangles, ready lines held high
        display_ready     = 1'b1;
        u_if.i_rast_ready = 1'b1;
        push_tri(0, 1'b0);
        push_tri(1, 1'b0);
        push_tri(2, 1'b1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("t1_clear", 64'(clear), 64'd1);
        chk("t1_busy", 64'(busy), 64'd1);
        tick();
        chk("t1_clear_once", 64'(clear), 64'd0);
        prev = 0;
        for (int j = 0; j < 3; j++) begin
            wait_dv(12, t, seen);
            chk("t1_dv_seen", 64'(seen), 64'd1);
            if (j > 0) chk("t1_dv_spacing", 64'(t - prev), 64'd2);
            chk("t1_last", 64'(u_if.o_rast_last), 64'(j == 2));
            chk("t1_v0", 64'(u_if.o_rast_v0), 64'(vtx(j)));
            chk("t1_v2", 64'(u_if.o_rast_v2), 64'(vtx(j + 100)));
            chk("t1_color", 64'(u_if.o_color), 64'(j));
            prev = t;
            tick();
        end
        chk("t1_count", 64'(tri_count), 64'd3);
        chk("t1_v0_hold", 64'(u_if.o_rast_v0), 64'(vtx(2)));
        chk("t1_dv_low", 64'(u_if.o_rast_dv), 64'd0);
        tick();
        chk("t1_wait_no_done", 64'(frame_done), 64'd0);
        finish_frame("t1");
        chk("t1_count_clr", 64'(tri_count), 64'd0);

        // FIFO full with no frame start; order preserved
        push_tri(10, 1'b0);
        push_tri(11, 1'b0);
        push_tri(12, 1'b0);
        chk("t2_ready_3", 64'(u_if.o_tri_ready), 64'd1);
        push_tri(13, 1'b1);
        chk("t2_full", 64'(u_if.o_tri_ready), 64'd0);
        push_tri(14, 1'b0);
        chk("t2_full_hold", 64'(u_if.o_tri_ready), 64'd0);
        chk("t2_idle", 64'(busy), 64'd0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int j = 0; j < 4; j++) begin
            wait_dv(12, t, seen);
            chk("t2_dv_seen", 64'(seen), 64'd1);
            chk("t2_order", 64'(u_if.o_rast_v0), 64'(vtx(10 + j)));
            chk("t2_last", 64'(u_if.o_rast_last), 64'(j == 3));
            tick();
        end
        chk("t2_count", 64'(tri_count), 64'd4);
        finish_frame("t2");

        // Display stall after clear, then colour hold with a slow rasterizer
        display_ready = 1'b0;
        cols[0] = 4'd2;
        cols[1] = 4'd7;
        cols[2] = 4'd5;
        for (int j = 0; j < 3; j++) begin
            u_if.i_tri_valid = 1'b1;
            u_if.i_tri_v0    = vtx(20 + j);
            u_if.i_tri_v1    = vtx(70 + j);
            u_if.i_tri_v2    = vtx(120 + j);
            u_if.i_tri_color = cols[j];
            u_if.i_tri_last  = (j == 2);
            tick();
            u_if.i_tri_valid = 1'b0;
        end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("t4_clear", 64'(clear), 64'd1);
        for (int n = 0; n < 20; n++) begin
            tick();
            chk("t4_no_dv", 64'(u_if.o_rast_dv), 64'd0);
        end
        display_ready = 1'b1;
        rcyc = cyc;
        held = 4'hD;
        for (int j = 0; j < 3; j++) begin
            seen = 1'b0;
            for (int n = 0; n < 20 && !seen; n++) begin
                if (u_if.o_rast_dv) begin
                    seen = 1'b1;
                end else begin
                    chk("t3_color_hold", 64'(u_if.o_color), 64'(held));
                    tick();
                end
            end
            chk("t3_dv_seen", 64'(seen), 64'd1);
            if (j == 0) chk("t4_issue_after_ready", 64'(cyc - rcyc), 64'd2);
            chk("t3_color", 64'(u_if.o_color), 64'(cols[j]));
            held = cols[j];
            u_if.i_rast_ready = 1'b0;
            for (int n = 0; n < 10; n++) begin
                tick();
                chk("t3_stall_dv", 64'(u_if.o_rast_dv), 64'd0);
                chk("t3_stall_color", 64'(u_if.o_color), 64'(held));
            end
            u_if.i_rast_ready = 1'b1;
        end
        finish_frame("t3");
        chk("t3_color_idle", 64'(u_if.o_color), 64'd5);

        // Frame start during FEED is flagged but changes nothing
        push_tri(30, 1'b0);
        push_tri(31, 1'b1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        wait_dv(12, t, seen);
        chk("t5_dv0_seen", 64'(seen), 64'd1);
        prev = t;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("t5_missed", 64'(missed), 64'd1);
        wait_dv(12, t, seen);
        chk("t5_dv1_seen", 64'(seen), 64'd1);
        chk("t5_spacing", 64'(t - prev), 64'd2);
        chk("t5_v0", 64'(u_if.o_rast_v0), 64'(vtx(31)));
        chk("t5_last", 64'(u_if.o_rast_last), 64'd1);
        tick();
        finish_frame("t5");
        chk("t5_missed_sticky", 64'(missed), 64'd1);

        // Reset in WAIT_RAST with two entries still queued
        push_tri(40, 1'b1);
        push_tri(41, 1'b0);
        push_tri(42, 1'b0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        wait_dv(12, t, seen);
        chk("t6_dv_seen", 64'(seen), 64'd1);
        chk("t6_v0", 64'(u_if.o_rast_v0), 64'(vtx(40)));
        tick();
        tick();
        chk("t6_wait_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #2;
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_color", 64'(u_if.o_color), 64'd0);
        chk("t6_rst_missed", 64'(missed), 64'd0);
        chk("t6_rst_ready", 64'(u_if.o_tri_ready), 64'd1);
        tick();
        rst = 1'b0;
        tick();
        chk("t6_no_done", 64'(frame_done), 64'd0);
        chk("t6_idle", 64'(busy), 64'd0);
        push_tri(50, 1'b1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        wait_dv(12, t, seen);
        chk("t6_new_dv_seen", 64'(seen), 64'd1);
        chk("t6_fifo_flushed", 64'(u_if.o_rast_v0), 64'(vtx(50)));
        tick();
        chk("t6_count", 64'(tri_count), 64'd1);
        finish_frame("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/render_scheduler.md
# render_scheduler

Frame-level controller that sits between the triangle source and the `rasterizer`/`display` pair. It buffers incoming triangles in a small FIFO and waits for a frame start. It then clears the framebuffer/depth buffer through `display` and issues buffered triangles to `rasterizer` one at a time, holding each triangle's colour index stable while that triangle is rasterized. When the last triangle has finished it reports frame completion.

## Interface
- DATAWIDTH, 12, width of each vertex coordinate (x, y, z)
- COLORWIDTH, 4, colour lookup index width
- FIFO_DEPTH, 4, triangle FIFO entries (power of two, ≥2)

- clk  in  1  system clock (rasterizer/framebuffer write domain)
- rst  in  1  asynchronous, active-high reset
- i_frame_start  in  1  one-cycle pulse per displayed frame, already synchronised to clk
- i_tri_valid  in  1  source triangle valid
- o_tri_ready  out  1  FIFO can accept (= not full)
- i_tri_v0, i_tri_v1, i_tri_v2  in  3*DATAWIDTH each  packed {z, y, x}, signed x/y, unsigned z
- i_tri_color  in  COLORWIDTH  colour index
- i_tri_last  in  1  marks final triangle of the frame
- o_clear  out  1  one-cycle clear request to display
- i_display_ready  in  1  display idle (clear complete)
- i_rast_ready  in  1  rasterizer can accept a triangle
- o_rast_v0, o_rast_v1, o_rast_v2  out  3*DATAWIDTH each  triangle to rasterizer
- o_rast_dv  out  1  one-cycle triangle strobe
- o_rast_last  out  1  qualifies o_rast_dv
- o_color  out  COLORWIDTH  colour index of triangle currently being rasterized
- i_rast_finished  in  1  rasterizer finished pulse after a last triangle
- o_busy  out  1  state ≠ IDLE
- o_frame_done  out  1  one-cycle pulse at end of frame
- o_missed_frame  out  1  sticky flag, frame start arrived while busy
- o_tri_count  out  16  triangles issued in current frame, saturating

## Operation
- FIFO entry: {last, color, v2, v1, v0}, width 9*DATAWIDTH+COLORWIDTH+1.
- Push when i_tri_valid && o_tri_ready. This is independent of the FSM, so triangles for the next frame may queue early.
- o_tri_ready = !full, computed from the registered count. A pop in the same cycle does not open a slot.
- FSM states:
  - IDLE: on i_frame_start → CLEAR.
  - CLEAR: o_clear=1 for exactly this cycle → WAIT_CLEAR.
  - WAIT_CLEAR: one guard cycle is mandatory. After that, → FEED on i_display_ready=1.
  - FEED: when FIFO non-empty, i_rast_ready=1 and the gap counter is zero:
    - pop the FIFO, drive o_rast_v*/o_rast_last from the entry and set o_rast_dv=1 for one cycle;
    - load o_color, increment o_tri_count and set gap=1;
    - if the entry is last → WAIT_RAST, else stay in FEED.
  - WAIT_RAST: on i_rast_finished → DONE.
  - DONE: o_frame_done=1 for one cycle; o_tri_count is reset to 0 → IDLE.
- Gap counter: after any issue, i_rast_ready is ignored for one cycle because the rasterizer drops ready one cycle after the strobe.
- o_color holds its value until the next issue, including through WAIT_RAST/DONE/IDLE.
- o_rast_v*/o_rast_last are registered and hold their values between strobes.
- i_frame_start in any state other than IDLE is ignored and sets o_missed_frame. The flag is cleared only by rst.
- i_rast_finished outside WAIT_RAST is ignored.
- An empty FIFO in FEED stalls indefinitely. There is no timeout.

## Timing
- Reset (async assert, sync release) values:
  - state=IDLE, FIFO empty, o_tri_ready=1;
  - all other outputs 0, including o_color and the o_rast_* buses.
- Reset mid-frame discards FIFO contents and any in-flight triangle. No o_frame_done is produced.
- i_frame_start at cycle T → o_clear at T+1.
- Earliest FEED entry is T+3, if i_display_ready is already high at T+3.
- FIFO latency: a push at cycle P is eligible for issue at P+1 (registered write, first-word visible next cycle).
- Issue throughput: at most one triangle per 2 cycles.
- i_rast_finished at cycle F → o_frame_done at F+1 → IDLE at F+2.
- i_frame_start in the same cycle as the DONE→IDLE transition is counted as missed.

## Test plan
- Reset, then push 3 triangles (last on #3), then pulse i_frame_start with ready/display ready held high:
  - o_clear one cycle later;
  - three o_rast_dv pulses, 2 cycles apart;
  - o_rast_last on the third only;
  - o_tri_count=3, then o_frame_done one cycle after i_rast_finished.
- Push 4 triangles with FIFO_DEPTH=4 and no frame start: o_tri_ready=0 after the 4th. A 5th valid is not accepted, and the FIFO contents are preserved in order.
- Colour check: triangles with colors 2, 7, 5 and i_rast_ready low for 10 cycles after each issue: o_color holds 2, then 7, then 5. Each value changes only on an o_rast_dv cycle.
- Hold i_display_ready low 20 cycles after o_clear: no o_rast_dv during those cycles; issue begins on the cycle after ready rises.
- i_frame_start pulsed during FEED: o_missed_frame=1 and stays set. The FSM path and issue sequence are unchanged.
- Assert rst while in WAIT_RAST with 2 queued entries: next cycle state=IDLE, FIFO empty, o_color=0, no o_frame_done. A following normal frame completes correctly.
